alu_mul_seq: RTL and testbench

- Parametrised sequential radix-4 Booth multiplier. It is the multi-cycle successor to the combinational ALU multiplier.
- Serves the MUL path of the datapath ALU. The control unit issues a start pulse and stalls until done.
- Adds a runtime signed/unsigned mode, a start/busy/done handshake, and a WIDTH-generic operand size.
- Frees the critical path from a single-cycle 32x32 array.

---
 rtl/alu_mul_seq.sv | 161 ++++++++++++++++
 tb/tb_alu_mul_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Latency: start accepted at edge E0 -> done pulse in the cycle after edge E0+ITER (ITER=(WIDTH+2)/2).
// Backpressure: none; start is only sampled in IDLE/DONE and ignored while busy. Optional macro: ALU_MUL_SEQ_EARLY_EXIT_EN.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    // Operands are carried with two extension bits so unsigned values stay positive
    // under signed Booth recoding; the iteration count covers all extended bits.
    localparam int EW   = WIDTH + 2;
    localparam int ITER = (WIDTH + 2) / 2;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   mcand_q, mcand_d;
    logic [EW-1:0]   hi_q, hi_d;
    logic [EW-1:0]   lo_q, lo_d;
    logic            guard_q, guard_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    logic            accept;
    logic [EW-1:0]   a_ext, b_ext;
    logic [2:0]      booth_bits;
    logic [EW+1:0]   mc_x, pp, sum;
    logic [EW-1:0]   hi_n, lo_n;
    logic            guard_n;
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
    logic            zero_op;
`endif

    // Operand extension at acceptance: sign-extend in signed mode, zero-extend otherwise.
    always_comb begin
        a_ext = signed_mode ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
        b_ext = signed_mode ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
        zero_op = (A == '0) || (B == '0);
`endif
    end

    // One Booth step: recode {lo[1:0], guard}, add digit*multiplicand to the upper half, shift right by 2.
    always_comb begin
        booth_bits = {lo_q[1:0], guard_q};
        mc_x       = {{2{mcand_q[EW-1]}}, mcand_q};
        pp         = '0;
        case (booth_bits)
            3'b001, 3'b010: pp = mc_x;
            3'b011:         pp = mc_x << 1;
            3'b100:         pp = '0 - (mc_x << 1);
            3'b101, 3'b110: pp = '0 - mc_x;
            default:        pp = '0;
        endcase
        sum     = {{2{hi_q[EW-1]}}, hi_q} + pp;
        // The shifted partial sum always fits back into EW bits, so the top two
        // sum bits are pure sign copies and can be dropped after the shift.
        hi_n    = sum[EW+1:2];
        lo_n    = {sum[1:0], lo_q[EW-1:2]};
        guard_n = lo_q[1];
    end

    // Next-state logic: accept in IDLE/DONE, count down in RUN, single-cycle DONE.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
                    if (zero_op) begin
                        state_d = S_DONE;
                    end
`endif
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: load on accept, iterate in RUN, publish P on the last step only.
    always_comb begin
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        guard_d = guard_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        if (accept) begin
            mcand_d = a_ext;
            hi_d    = '0;
            lo_d    = b_ext;
            guard_d = 1'b0;
            cnt_d   = CW'(ITER);
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
            if (zero_op) begin
                cnt_d = '0;
                p_d   = '0;
            end
`endif
        end else if (state_q == S_RUN) begin
            hi_d    = hi_n;
            lo_d    = lo_n;
            guard_d = guard_n;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                // After ITER double-bit shifts the full product sits in {hi, lo}; keep the low 2*WIDTH bits.
                p_d = {hi_n[WIDTH-3:0], lo_n};
            end
        end
    end

    // State and datapath registers with synchronous clear taking priority.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            guard_q <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            guard_q <= guard_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign P    = p_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq: behavioural model plus per-cycle compare and directed literal checks.
module tb_alu_mul_seq;
    localparam int W    = 32;
    localparam int ITER = (W + 2) / 2;

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic          sm;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [2*W-1:0] p;

    always #5 clk = ~clk;

    alu_mul_seq #(.WIDTH(W)) dut (
        .clk(clk), .clr(clr), .start(start), .signed_mode(sm),
        .A(a), .B(b), .busy(busy), .done(done), .P(p)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Exact product modulo 2^64 of the two operands interpreted per mode.
    function automatic logic [63:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [63:0] ex, ey;
        ex = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        ey = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        return ex * ey;
    endfunction

    // Behavioural model: cycles of work remaining, pending result, published result.
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [63:0] m_p    = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clk) begin
        cyc++;
        if (clr) begin
            m_left = 0;
            m_done = 1'b0;
            m_p    = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_p    = m_pend;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
                if (a == '0 || b == '0) begin
                    m_done = 1'b1;
                    m_p    = '0;
                end else begin
                    m_pend = ref_mul(a, b, sm);
                    m_left = ITER;
                end
`else
                m_pend = ref_mul(a, b, sm);
                m_left = ITER;
`endif
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {63'd0, busy}, {63'd0, (m_left > 0)});
            chk("done", {63'd0, done}, {63'd0, m_done});
            chk("P",    p, m_p);
        end
    end

    task automatic wait_done(input string name, output bit got, output int n, output int nb);
        got = 1'b0;
        n   = 0;
        nb  = 0;
        for (int i = 0; i < 60; i++) begin
            if (i > 0) @(negedge clk);
            if (busy) nb++;
            if (done) begin
                got = 1'b1;
                n   = i + 1;
                break;
            end
        end
        if (!got) chk({name, " timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsm,
                          input logic [63:0] exp, input bit lit, input string name);
        bit got;
        int n, nb, exp_n, exp_nb;
        exp_n  = ITER + 1;
        exp_nb = ITER;
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
        if (ta == '0 || tb_v == '0) begin
            exp_n  = 1;
            exp_nb = 0;
        end
`endif
        @(negedge clk);
        a = ta; b = tb_v; sm = tsm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; sm = 1'($urandom);
        wait_done(name, got, n, nb);
        if (got) begin
            if (lit) chk({name, " P"}, p, exp);
            chk({name, " latency"}, 64'(n), 64'(exp_n));
            chk({name, " busy cycles"}, 64'(nb), 64'(exp_nb));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int n, nb, t1, t2, ndone;
        clr = 1'b1; start = 1'b0; sm = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        clr = 1'b0;
        @(negedge clk);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset P", p, 64'd0);

        run_op(32'h000001F9, 32'h000000F0, 1'b0, 64'h000000000001D970, 1'b1, "unsigned small");
        run_op(32'h0000008B, 32'hFFFFFF74, 1'b1, 64'hFFFFFFFFFFFFB3FC, 1'b1, "signed mixed");
        run_op(32'hFFFFFF10, 32'hFFFFFF7B, 1'b1, 64'h0000000000007CB0, 1'b1, "signed neg neg");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b1, "unsigned max");
        run_op(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 1'b1, "signed min min");

        // start re-asserted mid-RUN is ignored; P holds its old value until done.
        @(negedge clk);
        a = 32'hFFFFFF10; b = 32'hFFFFFF7B; sm = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        a = 32'h00012345; b = 32'h00000777; sm = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("poke busy", {63'd0, busy}, 64'd1);
        chk("poke P hold", p, 64'h4000000000000000);
        wait_done("poke", got, n, nb);
        if (got) chk("poke P", p, 64'h0000000000007CB0);

        // Back-to-back: start held through DONE launches the next op; done spacing ITER+1.
        @(negedge clk);
        a = 32'h000001F9; b = 32'h000000F0; sm = 1'b0; start = 1'b1;
        wait_done("b2b first", got, n, nb);
        t1 = cyc;
        if (got) chk("b2b first P", p, 64'h000000000001D970);
        a = 32'h0000008B; b = 32'hFFFFFF74; sm = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b second", got, n, nb);
        t2 = cyc;
        if (got) begin
            chk("b2b second P", p, 64'hFFFFFFFFFFFFB3FC);
            chk("b2b spacing", 64'(t2 - t1), 64'(ITER + 1));
        end

        // Abort: clr during RUN kills the operation with no done pulse.
        @(negedge clk);
        a = 32'h00000123; b = 32'h00000456; sm = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("abort busy", {63'd0, busy}, 64'd0);
        chk("abort done", {63'd0, done}, 64'd0);
        chk("abort P", p, 64'd0);
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort no done", 64'(ndone), 64'd0);

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
        run_op(32'h00000000, 32'h00001234, 1'b0, 64'd0, 1'b1, "early exit");
`else
        run_op(32'h00000000, 32'h00001234, 1'b0, 64'd0, 1'b1, "zero operand");
`endif

        // Randomised operations, including corner operand values and idle gaps.
        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] ra, rb;
            int sel;
            sel = $urandom_range(0, 6);
            ra = (sel == 0) ? '0 : (sel == 1) ? '1 : (sel == 2) ? 32'h80000000 : 32'($urandom);
            sel = $urandom_range(0, 6);
            rb = (sel == 0) ? '0 : (sel == 1) ? '1 : (sel == 2) ? 32'h80000000 : 32'($urandom);
            run_op(ra, rb, 1'($urandom), ref_mul(ra, rb, 1'b0), 1'b0, "random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
